// File: rtl/div_share_sched_pkg.sv
// Shared types and default widths for the shared divider scheduler.
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned VW_DEF    = 4;
  localparam int unsigned N_REQ_DEF = 4;

  // Requester id width; a single requester still gets a one-bit id.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_share_sched_if.sv
// Request/response bundle between datapath clients (master) and the scheduler (slave).
interface div_share_sched_if
  import div_sched_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned VW    = VW_DEF
);
  localparam int unsigned IW = id_width(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] dividend_i;
  logic [N_REQ*VW-1:0] divisor_i;
  logic [N_REQ-1:0]    gnt;
  logic                busy;
  logic                rsp_valid;
  logic [IW-1:0]       rsp_id;
  logic [DW-1:0]       quotient_o;
  logic [VW-1:0]       remainder_o;
  logic                div_by_zero;

  modport master (
    output req, dividend_i, divisor_i,
    input  gnt, busy, rsp_valid, rsp_id, quotient_o, remainder_o, div_by_zero
  );

  modport slave (
    input  req, dividend_i, divisor_i,
    output gnt, busy, rsp_valid, rsp_id, quotient_o, remainder_o, div_by_zero
  );

endinterface

// File: rtl/div_share_sched_core.sv
// Iterative restoring divider datapath: one quotient bit per enabled step.
module restoring_div_core #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  input  logic          step_i,
  output logic [DW-1:0] q_o,
  output logic [VW-1:0] r_o
);

  logic [VW-1:0] r_q, r_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] dvs_q;
  logic [VW:0]   r_sh;
  logic [VW:0]   trial;
  logic [DW-1:0] q_sh;

  // Partial remainder is always below the divisor, so VW bits of storage suffice;
  // the shifted value and trial subtraction use VW+1 bits.
  always_comb begin
    {r_sh, q_sh} = {r_q, q_q, 1'b0};
    trial        = r_sh - {1'b0, dvs_q};
    r_d          = trial[VW] ? r_sh[VW-1:0] : trial[VW-1:0];
    q_d          = q_sh | DW'(!trial[VW]);
  end

  // Outputs show the value after the current step so the caller can capture the
  // final result on the last iteration edge.
  assign q_o = q_d;
  assign r_o = r_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      q_q   <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      r_q   <= '0;
      q_q   <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      r_q   <= r_d;
      q_q   <= q_d;
    end
  end

endmodule

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one restoring divider among N_REQ clients.
// Optional DIV_ZERO_DIVIDEND_SHORTCUT_EN: zero dividend skips the iterations.
module div_share_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned VW    = VW_DEF
) (
  input logic              clk,
  input logic              rst,
  div_share_sched_if.slave bus
);

  localparam int unsigned IW = id_width(N_REQ);
  localparam int unsigned CW = $clog2(DW + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    id_q, id_d;
  logic             dz_q, dz_d;
  logic             skip_q, skip_d;

  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]    rsp_id_q, rsp_id_d;
  logic [DW-1:0]    quo_q, quo_d;
  logic [VW-1:0]    rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             found;
  logic [IW-1:0]    win;
  logic [IW-1:0]    idx;
  logic [DW-1:0]    sel_dvd;
  logic [VW-1:0]    sel_dvs;
  logic             shortcut;
  logic             load;
  logic             step;
  logic [DW-1:0]    core_q;
  logic [VW-1:0]    core_r;

  // Round-robin pick: first set request strictly after rr_ptr, with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = IW'((32'(rr_ptr_q) + i) % N_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign sel_dvd = bus.dividend_i[32'(win)*DW +: DW];
  assign sel_dvs = bus.divisor_i[32'(win)*VW +: VW];

`ifdef DIV_ZERO_DIVIDEND_SHORTCUT_EN
  assign shortcut = (sel_dvd == '0);
`else
  assign shortcut = 1'b0;
`endif

  restoring_div_core #(.DW(DW), .VW(VW)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .dividend_i (sel_dvd),
    .divisor_i  (sel_dvs),
    .step_i     (step),
    .q_o        (core_q),
    .r_o        (core_r)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    dz_d        = dz_q;
    skip_d      = skip_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    load        = 1'b0;
    step        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d[win] = 1'b1;
          load       = 1'b1;
          rr_ptr_d   = win;
          id_d       = win;
          dz_d       = (sel_dvs == '0);
          skip_d     = (sel_dvs == '0) || shortcut;
          cnt_d      = CW'(DW);
          state_d    = CALC;
        end
      end
      CALC: begin
        // Zero-divisor / shortcut operations resolve without touching the datapath.
        if (skip_q) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          dbz_d       = dz_q;
          quo_d       = dz_q ? '1 : '0;
          rem_d       = '0;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            dbz_d       = 1'b0;
            quo_d       = core_q;
            rem_d       = core_r;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_ptr_q    <= IW'(N_REQ - 1);
      id_q        <= '0;
      dz_q        <= 1'b0;
      skip_q      <= 1'b0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      dz_q        <= dz_d;
      skip_q      <= skip_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.busy        = busy_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.quotient_o  = quo_q;
  assign bus.remainder_o = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_share_sched.sv
// Randomized bench for div_share_sched against an arithmetic reference model.
// Latency expectations follow DIV_ZERO_DIVIDEND_SHORTCUT_EN when it is defined.
module tb_div_share_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_share_sched_if #(.N_REQ(N), .DW(DW), .VW(VW)) bus ();

  div_share_sched #(.N_REQ(N), .DW(DW), .VW(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rr      = N - 1;
  int last_d  = 0;
  logic [7:0] dvd [4];
  logic [3:0] dvs [4];
  int  w;
  bit  seen;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_ops();
    for (int k = 0; k < 4; k++) begin
      bus.dividend_i[k*8 +: 8] = dvd[k];
      bus.divisor_i[k*4 +: 4]  = dvs[k];
    end
  endtask

  // Reference arbitration: first requester after the last winner, wrapping.
  function automatic int pick(input logic [3:0] m, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (m[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    repeat (3) tick();
    rst = 1'b0;
    rr = N - 1;
  endtask

  // One full operation: wait grant, check it, wait response, check result and hold.
  task automatic run_op(input logic [3:0] after_gnt, input bit junk, input bit gap_chk);
    int ew, el, g, n;
    logic [7:0] a, eq;
    logic [3:0] b, er;
    bit ez;
    ew = pick(bus.req, rr);
    if (ew < 0) begin
      check_eq("no_request", 0, 1);
      return;
    end
    a = dvd[ew];
    b = dvs[ew];
    if (b == 0) begin
      eq = 8'hFF; er = 4'h0; ez = 1'b1; el = 1;
    end else begin
      eq = a / b; er = 4'(a % b); ez = 1'b0; el = DW;
`ifdef DIV_ZERO_DIVIDEND_SHORTCUT_EN
      if (a == 0) el = 1;
`endif
    end
    n = 0;
    while (bus.gnt == '0 && n < 40) begin tick(); n++; end
    if (bus.gnt == '0) begin
      check_eq("gnt_timeout", 1, 0);
      return;
    end
    g = cyc;
    check_eq("gnt_onehot", 32'(bus.gnt), 32'(1) << ew);
    check_eq("busy_at_gnt", 32'(bus.busy), 1);
    if (gap_chk) check_eq("gnt_gap", g - last_d, 2);
    rr = ew;
    bus.req = junk ? 4'($urandom) : after_gnt;
    tick();
    check_eq("gnt_pulse", 32'(bus.gnt), 0);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin tick(); n++; end
    if (!bus.rsp_valid) begin
      check_eq("rsp_timeout", 1, 0);
      return;
    end
    last_d = cyc;
    check_eq("latency", cyc - g, el);
    check_eq("rsp_id", 32'(bus.rsp_id), ew);
    check_eq("quotient", 32'(bus.quotient_o), 32'(eq));
    check_eq("remainder", 32'(bus.remainder_o), 32'(er));
    check_eq("div_by_zero", 32'(bus.div_by_zero), 32'(ez));
    if (junk) bus.req = after_gnt;
    tick();
    check_eq("rsp_pulse", 32'(bus.rsp_valid), 0);
    check_eq("quotient_hold", 32'(bus.quotient_o), 32'(eq));
    check_eq("busy_idle", 32'(bus.busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.req = '0;
    for (int k = 0; k < 4; k++) begin dvd[k] = '0; dvs[k] = '0; end
    put_ops();
    repeat (3) tick();
    rst = 1'b0;

    check_eq("rst_gnt", 32'(bus.gnt), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check_eq("rst_rsp_id", 32'(bus.rsp_id), 0);
    check_eq("rst_quotient", 32'(bus.quotient_o), 0);
    check_eq("rst_remainder", 32'(bus.remainder_o), 0);
    check_eq("rst_dbz", 32'(bus.div_by_zero), 0);

    // 200/7 from requester 0.
    dvd[0] = 8'd200; dvs[0] = 4'd7; put_ops();
    bus.req = 4'b0001;
    run_op(4'b0000, 1'b0, 1'b0);

    // 55/0 from requester 2.
    dvd[2] = 8'd55; dvs[2] = 4'd0; put_ops();
    bus.req = 4'b0100;
    run_op(4'b0000, 1'b0, 1'b0);

    // Reset in the fourth iteration of 100/3 aborts it silently.
    dvd[1] = 8'd100; dvs[1] = 4'd3; put_ops();
    bus.req = 4'b0010;
    w = 0;
    while (bus.gnt == '0 && w < 40) begin tick(); w++; end
    check_eq("abort_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr = N - 1;
    check_eq("abort_busy", 32'(bus.busy), 0);
    check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    check_eq("abort_quotient", 32'(bus.quotient_o), 0);
    check_eq("abort_remainder", 32'(bus.remainder_o), 0);
    check_eq("abort_rsp_id", 32'(bus.rsp_id), 0);
    check_eq("abort_dbz", 32'(bus.div_by_zero), 0);
    check_eq("abort_gnt_low", 32'(bus.gnt), 0);
    seen = 1'b0;
    repeat (12) begin tick(); if (bus.rsp_valid) seen = 1'b1; end
    check_eq("abort_no_rsp", 32'(seen), 0);
    bus.req = 4'b0010;
    run_op(4'b0000, 1'b0, 1'b0);

    // All requesters held continuously from reset: grants 0,1,2,3.
    do_reset();
    dvd[0] = 8'd15;  dvs[0] = 4'd15;
    dvd[1] = 8'd14;  dvs[1] = 4'd15;
    dvd[2] = 8'd255; dvs[2] = 4'd1;
    dvd[3] = 8'd0;   dvs[3] = 4'd5;
    put_ops();
    bus.req = 4'b1111;
    run_op(4'b1111, 1'b0, 1'b0);
    run_op(4'b1111, 1'b0, 1'b1);
    run_op(4'b1111, 1'b0, 1'b1);
    run_op(4'b1010, 1'b0, 1'b1);
    run_op(4'b1000, 1'b0, 1'b1);
    run_op(4'b0000, 1'b0, 1'b1);

    // Random traffic with request noise while busy.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 4; k++) begin
        dvd[k] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        dvs[k] = 4'($urandom_range(0, 15));
      end
      put_ops();
      bus.req = 4'($urandom_range(1, 15));
      run_op(4'b0000, 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
